uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 SHALL have parameter START_TIMEOUT, default 8, meaning the maximum number of cycles from issuing a write to seeing tx_busy_i rise.
REQ-003 SHALL have ports, one per line:
- clock_i  in  1  sole clock; all logic on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester byte-send request; level.
- lock_i  in  NUM_REQ  per-requester hold-ownership request (multi-byte packets).
- data_i  in  8*NUM_REQ  requester k byte in bits [8k+7:8k].
- ack_o  out  NUM_REQ  one-hot, 1-cycle pulse when requester k's byte is accepted.
- owner_o  out  NUM_REQ  one-hot current locked owner; 0 if none.
- tx_write_o  out  1  write strobe to the shared UART transmitter.
- tx_data_o  out  8  byte to the UART transmitter.
- tx_busy_i  in  1  busy flag from the UART transmitter.
- error_o  out  1  1-cycle pulse on start timeout.

Function
REQ-004 SHALL implement the states IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-005 IDLE: SHALL arbitrate only when tx_busy_i=0 and req_i!=0; otherwise remain in IDLE.
REQ-006 Arbitration SHALL be round-robin: search from rr_ptr upward, wrapping mod NUM_REQ; the first set req_i bit wins.
REQ-007 If owner_o!=0 and the owner's lock_i bit is 1, only the owner SHALL be eligible; other requests SHALL wait, even if the owner's req_i is 0.
REQ-008 If the owner's lock_i bit is 0 in IDLE, owner_o SHALL clear in the same evaluation and normal round-robin SHALL apply.
REQ-009 On a win by requester w in IDLE at cycle N: state SHALL become ISSUE at N+1, with tx_write_o=1, tx_data_o=data_i[w] as registered at N, and ack_o[w]=1, all for exactly that one cycle.
REQ-010 On the same win, rr_ptr SHALL become (w+1) mod NUM_REQ, and owner_o SHALL become onehot(w) if lock_i[w]=1 at N, else 0.
REQ-011 ISSUE SHALL always advance to WAIT_START; tx_write_o and ack_o SHALL return to 0.
REQ-012 WAIT_START SHALL go to WAIT_DONE when tx_busy_i=1.
REQ-013 If tx_busy_i does not rise within START_TIMEOUT cycles of WAIT_START, the block SHALL pulse error_o for one cycle and return to IDLE; owner_o SHALL be retained.
REQ-014 WAIT_DONE SHALL return to IDLE on the first cycle with tx_busy_i=0.
REQ-015 tx_data_o SHALL hold the last issued byte until the next ISSUE.
REQ-016 req_i and lock_i SHALL be sampled only in IDLE; changes in other states SHALL be ignored.
REQ-017 A requester SHALL hold data_i stable from req rise until its ack; ack_o SHALL never exceed one pulse per ISSUE.
REQ-018 Exactly one tx_write_o pulse SHALL occur per IDLE->ISSUE transition; a requester holding req_i high continuously SHALL get one byte per completed transfer, never back-to-back writes.
REQ-019 Minimum spacing between tx_write_o pulses SHALL be 4 cycles (ISSUE, WAIT_START, WAIT_DONE, IDLE).

Reset
REQ-020 reset_i=1 at a rising edge SHALL force, on that edge: state=IDLE, rr_ptr=0, owner_o=0, ack_o=0, tx_write_o=0, tx_data_o=8'h00, error_o=0, timeout counter=0.
REQ-021 Reset SHALL take priority over every transition, including mid-ISSUE; a write in flight SHALL be abandoned without ack.
REQ-022 After reset, the first issue SHALL wait for tx_busy_i=0, since the transmitter may report busy for a post-reset interval.

Verification
REQ-023 Reset with tx_busy_i=1 held 20 cycles and req_i=4'b0001 -> no tx_write_o until 1 cycle after tx_busy_i falls; then tx_data_o=data_i[7:0], ack_o=4'b0001.
REQ-024 req_i=4'b1111 held, data bytes 8'h11/22/33/44, busy model 10 cycles -> writes in order 11,22,33,44,11, one ack each.
REQ-025 Requester 2 with lock_i[2]=1 sends 3 bytes while req_i=4'b1111 -> three consecutive grants to 2 with owner_o=4'b0100; after lock_i[2]=0, next grant goes to 3.
REQ-026 Busy model never rises -> error_o pulses exactly START_TIMEOUT cycles after WAIT_START entry, state returns to IDLE, next request is served.
REQ-027 reset_i=1 in the ISSUE cycle -> next cycle tx_write_o=0, ack_o=0, owner_o=0, rr_ptr=0.
REQ-028 req_i=4'b0001 held constantly -> tx_write_o pulses never closer than the busy duration plus 3 cycles, and exactly one ack per pulse.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//             byte producers. A requester may hold ownership with lock_i
//             so that a multi-byte packet goes out uninterrupted. Each
//             transfer is issued, then confirmed by tx_busy_i rising and
//             falling. If busy never rises, a start-timeout error is pulsed.
//  Ports    : clock_i    - clock, rising edge
//             reset_i    - synchronous active-high reset
//             req_i      - per-requester send request (level)
//             lock_i     - per-requester hold-ownership request
//             data_i     - requester k byte in bits [8k+7:8k]
//             ack_o      - one-hot 1-cycle accept pulse
//             owner_o    - one-hot locked owner, 0 if none
//             tx_write_o - write strobe to the transmitter
//             tx_data_o  - byte to the transmitter (held until next issue)
//             tx_busy_i  - transmitter busy flag
//             error_o    - 1-cycle pulse on start timeout
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   lock_i,
    input  logic [8*NUM_REQ-1:0] data_i,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic [NUM_REQ-1:0]   owner_o,
    output logic                 tx_write_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic                 error_o
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(START_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_owner_locked;
    logic [NUM_REQ-1:0]   w_eligible;
    logic                 w_found;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [7:0]           w_win_data;
    logic                 w_win_lock;
    logic [c_PTR_W-1:0]   w_next_ptr;

    // Winner selection: a locked owner masks every other requester (even
    // when its own request is low); otherwise search upward from r_rr_ptr.
    always_comb begin
        int idx;
        idx            = 0;
        w_owner_locked = |(owner_o & lock_i);
        w_eligible     = w_owner_locked ? (req_i & owner_o) : req_i;
        w_found        = 1'b0;
        w_win_onehot   = '0;
        w_win_data     = '0;
        w_win_lock     = 1'b0;
        w_next_ptr     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && w_eligible[idx]) begin
                w_found           = 1'b1;
                w_win_onehot[idx] = 1'b1;
                w_win_data        = data_i[idx*8 +: 8];
                w_win_lock        = lock_i[idx];
                w_next_ptr        = (idx == NUM_REQ - 1) ? '0 : c_PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            owner_o    <= '0;
            ack_o      <= '0;
            tx_write_o <= 1'b0;
            tx_data_o  <= 8'h00;
            error_o    <= 1'b0;
        end else begin
            // Strobes are single-cycle by default.
            ack_o      <= '0;
            tx_write_o <= 1'b0;
            error_o    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Ownership lapses as soon as the owner drops its lock.
                    if (!w_owner_locked) begin
                        owner_o <= '0;
                    end
                    if (!tx_busy_i && w_found) begin
                        r_state    <= S_ISSUE;
                        tx_write_o <= 1'b1;
                        tx_data_o  <= w_win_data;
                        ack_o      <= w_win_onehot;
                        r_rr_ptr   <= w_next_ptr;
                        owner_o    <= w_win_lock ? w_win_onehot : '0;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_START;
                    r_cnt   <= '0;
                end
                S_WAIT_START: begin
                    if (tx_busy_i) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        // Transmitter never acknowledged; owner is kept so a
                        // locked packet can retry.
                        error_o <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
